fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 imemReq  output  1  instruction memory read request.
REQ-005 imemAddr  output  32  word address of the requested instruction; equals pcOut.
REQ-006 imemRdata  input  32  instruction word returned by memory.
REQ-007 imemValid  input  1  imemRdata valid this cycle; ignored unless imemReq=1.
REQ-008 instr  output  32  held instruction presented to the control unit and datapath.
REQ-009 instrValid  output  1  instr is valid and awaiting consumption.
REQ-010 instrReady  input  1  consumer accepts instr this cycle.
REQ-011 pcSrc  input  1  redirect select from the control unit; 1 selects pcTarget.
REQ-012 pcTarget  input  32  branch/jump target from the datapath.
REQ-013 pcOut  output  32  PC of the instruction being fetched or issued.
REQ-014 instrCount  output  32  count of issued instructions.
REQ-015 misaligned  output  1  target alignment fault flag; tied 0 when FETCH_MISALIGN_TRAP_EN is undefined.

Function
REQ-016 FSM states FETCH, ISSUE, HALT (HALT exists only with FETCH_MISALIGN_TRAP_EN).
REQ-017 FETCH: imemReq=1, instrValid=0; on imemValid=1, instr<=imemRdata, next state ISSUE.
REQ-018 FETCH with imemValid=0: hold state, pcOut and imemAddr stable; imemReq stays high indefinitely.
REQ-019 imemValid accepted in the first FETCH cycle; minimum fetch-to-issue latency is 1 cycle (instrValid high the cycle after imemValid).
REQ-020 ISSUE: imemReq=0, instrValid=1, instr and pcOut stable until instrReady=1.
REQ-021 Handshake cycle (ISSUE and instrReady=1): pcSrc and pcTarget are sampled; pcOut<=pcSrc ? pcTarget : pcOut+4; instrCount<=instrCount+1; next state FETCH.
REQ-022 pcSrc and pcTarget are ignored in all cycles other than the handshake cycle.
REQ-023 pcOut+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 instrCount wraps 32'hFFFF_FFFF -> 0 with no flag.
REQ-025 Issue throughput: at most one instruction per 2 cycles; no prefetch, no outstanding second request.

Reset
REQ-026 reset=0 at a rising edge: state<=FETCH, pcOut<=RESET_PC, instr<=0, instrCount<=0, misaligned<=0.
REQ-027 Outputs during and immediately after reset: instrValid=0; imemReq=1 from the first cycle with reset=1.
REQ-028 Reset mid-fetch or mid-issue discards the pending memory response and held instruction; no count increment.
REQ-029 Reset has priority over every other event in the same cycle, including a handshake.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: at handshake with pcSrc=1 and pcTarget[1:0]!=0, pcOut<=pcTarget unmodified, misaligned<=1, instrCount increments, state<=HALT.
REQ-031 HALT: imemReq=0, instrValid=0, misaligned=1; exit only by reset.
REQ-032 Macro undefined: pcTarget[1:0] forced to 2'b00 on redirect; no HALT state; misaligned constant 0.

Verification
REQ-033 Reset release, imemValid same cycle, instrReady=1 always -> imemAddr sequence 0,4,8 on alternating cycles; instrCount=3 after third handshake.
REQ-034 imemValid delayed 5 cycles -> imemReq high and imemAddr constant for 5 cycles; instrValid rises the cycle after imemValid.
REQ-035 instrReady low 3 cycles in ISSUE with pcSrc toggling -> instr, pcOut stable; only the value at the handshake cycle (pcSrc=1, pcTarget=32'h100) redirects; next imemAddr=32'h100.
REQ-036 RESET_PC=32'hFFFF_FFFC, no redirect -> second fetch address 32'h0000_0000.
REQ-037 Macro defined, redirect to 32'h102 -> misaligned=1, imemReq=0 thereafter; macro undefined -> next imemAddr=32'h100, misaligned=0.
REQ-038 reset=0 asserted in ISSUE during instrReady=1 -> pcOut=RESET_PC, instrCount=0, instrValid=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit : single-request instruction fetch with issue handshake         |
// | Optional target-alignment trap: define FETCH_MISALIGN_TRAP_EN               |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemRdata,
   input  logic        imemValid,
   output logic [31:0] instr,
   output logic        instrValid,
   input  logic        instrReady,
   input  logic        pcSrc,
   input  logic [31:0] pcTarget,
   output logic [31:0] pcOut,
   output logic [31:0] instrCount,
   output logic        misaligned
);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1
   } state_t;
`endif

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_count;
   logic [31:0] w_target;
   logic [31:0] w_nextPc;
   logic        w_handshake;
   logic        w_misTarget;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        r_misaligned;

   assign w_target    = pcTarget;
   assign w_misTarget = pcSrc && (pcTarget[1:0] != 2'b00);
   assign misaligned  = r_misaligned;
`else
   // Low address bits are dropped so a redirect always lands word-aligned.
   assign w_target    = pcTarget & 32'hFFFF_FFFC;
   assign w_misTarget = 1'b0;
   assign misaligned  = 1'b0;
`endif

   assign w_nextPc   = pcSrc ? w_target : (r_pc + 32'd4);
   assign pcOut      = r_pc;
   assign imemAddr   = r_pc;
   assign instr      = r_instr;
   assign instrCount = r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      imemReq     = 1'b0;
      instrValid  = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         FETCH: begin
            imemReq = 1'b1;
            if (imemValid) begin
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            instrValid = 1'b1;
            if (instrReady) begin
               w_handshake = 1'b1;
               w_nextState = w_misTarget ? state_t'(2'd2) : FETCH;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: begin
            w_nextState = HALT;
         end
`endif
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   // Only one request is ever outstanding, so the response can be latched directly.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'h0000_0000;
         r_count <= 32'h0000_0000;
      end else begin
         if ((r_state == FETCH) && imemValid) begin
            r_instr <= imemRdata;
         end
         if (w_handshake) begin
            r_pc    <= w_nextPc;
            r_count <= r_count + 32'd1;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_misaligned <= 1'b0;
      end else if (w_handshake && w_misTarget) begin
         r_misaligned <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire
